// File: rtl/umult_norm_pkg.sv
// Shared definitions for the multi-channel pixel x norm-factor stream multiplier:
// default widths, lane slicing and the clamping counter add.
package umult_norm_pkg;

    localparam int unsigned DEF_NUM_CH           = 4;
    localparam int unsigned DEF_INT_WIDTH        = 8;
    localparam int unsigned DEF_FRAC_WIDTH       = 16;
    localparam int unsigned DEF_MODULE_OUT_WIDTH = 8;
    localparam int unsigned DEF_SAT_CNT_WIDTH    = 16;

    localparam int unsigned BUS_MAX  = 256;
    localparam int unsigned LANE_MAX = 64;
    localparam int unsigned CNT_MAX  = 32;
    localparam int unsigned CNT_EXT  = CNT_MAX + 1;

    localparam bit DEF_WIDTHS_OK = (DEF_FRAC_WIDTH >= DEF_MODULE_OUT_WIDTH);

    function automatic bit widths_ok(input int unsigned frac_w, input int unsigned out_w);
        return frac_w >= out_w;
    endfunction

    // Extract lane k of width w from a packed multi-lane bus.
    function automatic logic [LANE_MAX-1:0] lane_slice(input logic [BUS_MAX-1:0] bus,
                                                       input int unsigned k,
                                                       input int unsigned w);
        logic [BUS_MAX-1:0]  shifted;
        logic [LANE_MAX-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (w >= LANE_MAX) ? '1 : ((LANE_MAX'(1) << w) - LANE_MAX'(1));
        return shifted[LANE_MAX-1:0] & mask;
    endfunction

    // a + b clamped to the all-ones value of a w-bit counter.
    function automatic logic [CNT_MAX-1:0] sat_add(input logic [CNT_MAX-1:0] a,
                                                   input logic [CNT_MAX-1:0] b,
                                                   input int unsigned w);
        logic [CNT_MAX:0] sum;
        logic [CNT_MAX:0] max;
        max = (w >= CNT_MAX) ? {1'b0, {CNT_MAX{1'b1}}} : ((CNT_EXT'(1) << w) - CNT_EXT'(1));
        sum = {1'b0, a} + {1'b0, b};
        return (sum > max) ? max[CNT_MAX-1:0] : sum[CNT_MAX-1:0];
    endfunction

endpackage

// File: rtl/umult_norm_lane.sv
// One channel: S1 multiply, S2 round/saturate/output register, both gated by the stall enable.
// Rounding selected by UMULT_NORM_ROUND_EN (undefined: truncate).
module umult_norm_lane #(
    parameter int unsigned INT_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [INT_WIDTH-1:0]  pixel,
    input  logic [FRAC_WIDTH-1:0] factor,
    output logic [OUT_WIDTH-1:0]  data,
    output logic                  sat
);

    localparam int unsigned PROD_WIDTH = INT_WIDTH + FRAC_WIDTH;
    localparam int unsigned EXT_WIDTH  = PROD_WIDTH + 1;
    localparam int unsigned LSB        = FRAC_WIDTH - OUT_WIDTH;

    logic [PROD_WIDTH-1:0] prod;
    logic [EXT_WIDTH-1:0]  rounded;
    logic [EXT_WIDTH-1:0]  shifted;
    logic                  sat_c;
    logic [OUT_WIDTH-1:0]  data_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod <= '0;
        end else if (en) begin
            prod <= PROD_WIDTH'(pixel) * PROD_WIDTH'(factor);
        end
    end

    // Extra top bit catches a rounding carry out of an all-ones integer part.
`ifdef UMULT_NORM_ROUND_EN
    if (LSB > 0) begin : g_round
        assign rounded = EXT_WIDTH'(prod) + (EXT_WIDTH'(1) << (LSB - 1));
    end else begin : g_exact
        assign rounded = EXT_WIDTH'(prod);
    end
`else
    assign rounded = EXT_WIDTH'(prod);
`endif

    assign shifted = rounded >> LSB;
    assign sat_c   = |(shifted >> OUT_WIDTH);
    assign data_c  = sat_c ? '1 : OUT_WIDTH'(shifted);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            sat  <= 1'b0;
        end else if (en) begin
            data <= data_c;
            sat  <= sat_c;
        end
    end

endmodule

// File: rtl/umult_norm_stream.sv
// Multi-channel pixel x norm-factor stream multiplier with per-frame saturation count.
// Optional round-half-up output via UMULT_NORM_ROUND_EN (default build truncates).
module umult_norm_stream
    import umult_norm_pkg::*;
#(
    parameter int unsigned NUM_CH           = DEF_NUM_CH,
    parameter int unsigned INT_WIDTH        = DEF_INT_WIDTH,
    parameter int unsigned FRAC_WIDTH       = DEF_FRAC_WIDTH,
    parameter int unsigned MODULE_OUT_WIDTH = DEF_MODULE_OUT_WIDTH,
    parameter int unsigned SAT_CNT_WIDTH    = DEF_SAT_CNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH*INT_WIDTH-1:0]        s_pixel_tdata,
    input  logic                               s_pixel_tvalid,
    input  logic                               s_pixel_tlast,
    output logic                               s_pixel_tready,
    input  logic [FRAC_WIDTH-1:0]              norm_factor,
    input  logic                               norm_factor_tvalid,
    output logic [NUM_CH*MODULE_OUT_WIDTH-1:0] m_tdata,
    output logic                               m_tvalid,
    output logic                               m_tlast,
    input  logic                               m_tready,
    output logic [SAT_CNT_WIDTH-1:0]           frame_sat_count,
    output logic                               frame_sat_valid
);

    if (!widths_ok(FRAC_WIDTH, MODULE_OUT_WIDTH) || NUM_CH * INT_WIDTH > BUS_MAX
        || SAT_CNT_WIDTH > CNT_MAX) begin : g_bad_cfg
        $error("umult_norm_stream: unsupported parameter combination");
    end

    logic                     en;
    logic                     take;
    logic                     swap;
    logic                     out_hs;
    logic [FRAC_WIDTH-1:0]    shadow;
    logic [FRAC_WIDTH-1:0]    active;
    logic [FRAC_WIDTH-1:0]    factor_c;
    logic                     pending;
    logic                     frame_start;
    logic                     s1_valid;
    logic                     s1_last;
    logic [NUM_CH-1:0]        lane_sat;
    logic [CNT_MAX-1:0]       beat_sat;
    logic [SAT_CNT_WIDTH-1:0] run_cnt;
    logic [SAT_CNT_WIDTH-1:0] total;

    assign en             = !m_tvalid || m_tready;
    assign s_pixel_tready = en;
    assign take           = s_pixel_tvalid && en;
    assign out_hs         = m_tvalid && m_tready;

    // A pending factor is promoted at a frame start and already applies to that beat.
    assign swap     = take && frame_start && pending;
    assign factor_c = swap ? shadow : active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            if (norm_factor_tvalid) begin
                shadow <= norm_factor;
            end
            if (norm_factor_tvalid) begin
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
            if (swap) begin
                active <= shadow;
            end
            if (take) begin
                frame_start <= s_pixel_tlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (en) begin
            s1_valid <= s_pixel_tvalid;
            s1_last  <= s_pixel_tvalid && s_pixel_tlast;
            m_tvalid <= s1_valid;
            m_tlast  <= s1_last;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        umult_norm_lane #(
            .INT_WIDTH  (INT_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH),
            .OUT_WIDTH  (MODULE_OUT_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .pixel  (INT_WIDTH'(lane_slice(BUS_MAX'(s_pixel_tdata), k, INT_WIDTH))),
            .factor (factor_c),
            .data   (m_tdata[k*MODULE_OUT_WIDTH +: MODULE_OUT_WIDTH]),
            .sat    (lane_sat[k])
        );
    end

    always_comb begin
        beat_sat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            beat_sat = beat_sat + CNT_MAX'(lane_sat[k]);
        end
    end

    assign total = SAT_CNT_WIDTH'(sat_add(CNT_MAX'(run_cnt), beat_sat, SAT_CNT_WIDTH));

    // Saturation tally is taken at the output handshake so stalls never double count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt         <= '0;
            frame_sat_count <= '0;
            frame_sat_valid <= 1'b0;
        end else begin
            frame_sat_valid <= 1'b0;
            if (out_hs) begin
                if (m_tlast) begin
                    frame_sat_count <= total;
                    frame_sat_valid <= 1'b1;
                    run_cnt         <= '0;
                end else begin
                    run_cnt <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_umult_norm_stream.sv
// Scoreboard bench for umult_norm_stream: arithmetic reference model feeds expected queues,
// an independent monitor compares every output handshake and saturation pulse.
module tb_umult_norm_stream;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned INT_WIDTH  = 8;
    localparam int unsigned FRAC_WIDTH = 16;
    localparam int unsigned OUT_WIDTH  = 8;
    localparam int unsigned SAT_WIDTH  = 8;
    localparam int unsigned SAT_MAX    = (1 << SAT_WIDTH) - 1;
    localparam int unsigned DW_IN      = NUM_CH * INT_WIDTH;
    localparam int unsigned DW_OUT     = NUM_CH * OUT_WIDTH;
`ifdef UMULT_NORM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [DW_IN-1:0]      s_pixel_tdata;
    logic                  s_pixel_tvalid;
    logic                  s_pixel_tlast;
    logic                  s_pixel_tready;
    logic [FRAC_WIDTH-1:0] norm_factor;
    logic                  norm_factor_tvalid;
    logic [DW_OUT-1:0]     m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready = 1'b1;
    logic [SAT_WIDTH-1:0]  frame_sat_count;
    logic                  frame_sat_valid;

    umult_norm_stream #(
        .NUM_CH           (NUM_CH),
        .INT_WIDTH        (INT_WIDTH),
        .FRAC_WIDTH       (FRAC_WIDTH),
        .MODULE_OUT_WIDTH (OUT_WIDTH),
        .SAT_CNT_WIDTH    (SAT_WIDTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_pixel_tdata      (s_pixel_tdata),
        .s_pixel_tvalid     (s_pixel_tvalid),
        .s_pixel_tlast      (s_pixel_tlast),
        .s_pixel_tready     (s_pixel_tready),
        .norm_factor        (norm_factor),
        .norm_factor_tvalid (norm_factor_tvalid),
        .m_tdata            (m_tdata),
        .m_tvalid           (m_tvalid),
        .m_tlast            (m_tlast),
        .m_tready           (m_tready),
        .frame_sat_count    (frame_sat_count),
        .frame_sat_valid    (frame_sat_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW_OUT-1:0] data;
        bit                last;
        int unsigned       acc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned sat_q[$];

    // Reference model state: factor bookkeeping and running saturation total.
    int unsigned m_sh, m_act, m_run;
    bit          m_pend, m_fs;

    int rdy_mode  = 0;
    bit lat_check = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void ref_lane(input int unsigned pix, input int unsigned f,
                                     output int unsigned y, output bit s);
        longint unsigned p;
        p = 64'(pix) * 64'(f);
        if (ROUND && FRAC_WIDTH > OUT_WIDTH) p = p + (64'd1 << (FRAC_WIDTH - OUT_WIDTH - 1));
        if (p >= (64'd1 << FRAC_WIDTH)) begin
            y = (1 << OUT_WIDTH) - 1;
            s = 1'b1;
        end else begin
            y = 32'(p >> (FRAC_WIDTH - OUT_WIDTH));
            s = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_sh = 0; m_act = 0; m_pend = 1'b0; m_fs = 1'b1; m_run = 0;
        exp_q.delete();
        sat_q.delete();
    endfunction

    function automatic void model_load(input int unsigned v);
        m_sh   = v;
        m_pend = 1'b1;
    endfunction

    function automatic void model_accept(input logic [DW_IN-1:0] pix, input bit last,
                                         input int unsigned acc);
        exp_t        e;
        int unsigned nsat, y;
        bit          s;
        if (m_fs && m_pend) begin
            m_act  = m_sh;
            m_pend = 1'b0;
        end
        nsat = 0;
        e.data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ref_lane(32'(pix[k*INT_WIDTH +: INT_WIDTH]), m_act, y, s);
            e.data[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(y);
            nsat += 32'(s);
        end
        e.last = last;
        e.acc  = acc;
        exp_q.push_back(e);
        m_run = (m_run + nsat > SAT_MAX) ? SAT_MAX : m_run + nsat;
        if (last) begin
            sat_q.push_back(m_run);
            m_run = 0;
        end
        m_fs = last;
    endfunction

    function automatic logic [DW_IN-1:0] pack(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    always @(negedge clk) begin
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom % 4) != 0;
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor: looks at the upcoming edge's handshake from the middle of the low phase.
    bit                exp_pulse = 1'b0;
    bit                stalled   = 1'b0;
    logic [DW_OUT-1:0] held_data;
    logic              held_last;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_pulse = 1'b0;
            stalled   = 1'b0;
        end else begin
            if (exp_pulse || frame_sat_valid) begin
                chk("frame_sat_valid", 64'(frame_sat_valid), 64'(exp_pulse));
                if (frame_sat_valid && exp_pulse) begin
                    if (sat_q.size() == 0) chk("sat_queue_empty", 64'(1), 64'(0));
                    else chk("frame_sat_count", 64'(frame_sat_count), 64'(sat_q.pop_front()));
                end
            end
            exp_pulse = 1'b0;
            if (stalled) begin
                chk("stall_valid", 64'(m_tvalid), 64'(1));
                chk("stall_data", 64'(m_tdata), 64'(held_data));
                chk("stall_last", 64'(m_tlast), 64'(held_last));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_tdata", 64'(m_tdata), 64'(e.data));
                    chk("m_tlast", 64'(m_tlast), 64'(e.last));
                    if (lat_check && !stalled) chk("latency", 64'(cyc - e.acc), 64'(2));
                end
                exp_pulse = m_tlast;
            end
            stalled   = m_tvalid && !m_tready;
            held_data = m_tdata;
            held_last = m_tlast;
        end
    end

    task automatic send_beat(input logic [DW_IN-1:0] pix, input bit last,
                             input bit ld, input int unsigned ldv);
        bit          first = 1'b1;
        bit          acc   = 1'b0;
        int unsigned acyc;
        int          guard = 0;
        while (!acc) begin
            @(negedge clk);
            s_pixel_tdata      = pix;
            s_pixel_tvalid     = 1'b1;
            s_pixel_tlast      = last;
            norm_factor_tvalid = first && ld;
            norm_factor        = FRAC_WIDTH'(ldv);
            #1;
            acc  = s_pixel_tready;
            acyc = cyc;
            @(posedge clk);
            if (acc) model_accept(pix, last, acyc);
            if (first && ld) model_load(ldv);
            first = 1'b0;
            guard++;
            if (guard > 2000) begin
                errors++;
                $display("FAIL input_accept_timeout: beat not accepted within 2000 cycles");
                $fatal(1, "input stalled");
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_pixel_tvalid     = 1'b0;
            norm_factor_tvalid = 1'b0;
        end
    endtask

    task automatic do_load(input int unsigned v);
        @(negedge clk);
        s_pixel_tvalid     = 1'b0;
        norm_factor_tvalid = 1'b1;
        norm_factor        = FRAC_WIDTH'(v);
        @(posedge clk);
        model_load(v);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            idle(1);
            g++;
        end
        if (g >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
        idle(4);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        s_pixel_tvalid     = 1'b0;
        norm_factor_tvalid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("reset_m_tdata", 64'(m_tdata), 64'(0));
        chk("reset_sat_valid", 64'(frame_sat_valid), 64'(0));
        chk("reset_sat_count", 64'(frame_sat_count), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n              = 1'b0;
        s_pixel_tdata      = '0;
        s_pixel_tvalid     = 1'b0;
        s_pixel_tlast      = 1'b0;
        norm_factor        = '0;
        norm_factor_tvalid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_tready", 64'(s_pixel_tready), 64'(1));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_sat_count", 64'(frame_sat_count), 64'(0));
        chk("rst_sat_valid", 64'(frame_sat_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic multiply and saturation on a single-beat frame.
        lat_check = 1'b1;
        do_load(32'h8000);
        send_beat(pack(8'h01, 8'h03, 8'h00, 8'h01), 1'b1, 1'b0, 0);
        wait_idle();

        // Rounding vs truncation boundary.
        do_load(32'h0180);
        send_beat(pack(8'h01, 8'h02, 8'h55, 8'h00), 1'b1, 1'b0, 0);
        wait_idle();

        // Ten-beat stream with a five-cycle downstream stall.
        lat_check = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_beat(pack(4*i, 4*i+1, 4*i+2, 4*i+3), i == 9, 1'b0, 0);
                idle(1);
            end
            begin
                @(negedge clk);
                #3 rdy_mode = 2;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    #3;
                    if (j >= 2) chk("stall_s_tready", 64'(s_pixel_tready), 64'(0));
                    if (j == 4) rdy_mode = 0;
                end
            end
        join
        wait_idle();

        // Factor timing: mid-frame load deferred, coincident load deferred one frame.
        lat_check = 1'b1;
        do_load(32'h1000);
        send_beat(pack(1, 2, 3, 4), 1'b0, 1'b0, 0);
        do_load(32'h4000);
        send_beat(pack(1, 2, 3, 4), 1'b1, 1'b0, 0);
        send_beat(pack(1, 2, 3, 4), 1'b0, 1'b1, 32'h2000);
        send_beat(pack(2, 3, 1, 1), 1'b1, 1'b0, 0);
        send_beat(pack(1, 2, 3, 4), 1'b1, 1'b0, 0);
        wait_idle();

        // Saturation counter clamps at all-ones.
        do_load(32'hFFFF);
        for (int i = 0; i < 80; i++)
            send_beat(pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), i == 79, 1'b0, 0);
        wait_idle();

        // Mid-frame reset drops in-flight beats; factor reverts to zero.
        do_load(32'h0100);
        for (int i = 0; i < 3; i++) send_beat(pack(9, 8, 7, 6), 1'b0, 1'b0, 0);
        pulse_reset();
        send_beat(pack(8'hFF, 8'h80, 8'h10, 8'h01), 1'b0, 1'b0, 0);
        send_beat(pack(8'hFF, 8'h80, 8'h10, 8'h01), 1'b1, 1'b0, 0);
        wait_idle();
        do_load(32'h0200);
        send_beat(pack(8'h10, 8'h20, 8'h90, 8'h01), 1'b1, 1'b0, 0);
        wait_idle();

        // Randomized traffic with random backpressure and factor loads.
        lat_check = 1'b0;
        rdy_mode  = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 10 == 0) do_load($urandom_range(0, 32'h03FF));
            send_beat(pack($urandom, $urandom, $urandom, $urandom), ($urandom % 6) == 0,
                      ($urandom % 8) == 0, $urandom_range(0, 32'h03FF));
            if ($urandom % 4 == 0) idle(1);
        end
        send_beat(pack($urandom, $urandom, $urandom, $urandom), 1'b1, 1'b0, 0);
        idle(1);
        rdy_mode = 0;
        wait_idle();
        chk("queues_drained", 64'(exp_q.size() + sat_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
